// File: rtl/pcie_mwr_tx.sv
// pcie_mwr_tx: posted-write TLP initiator (32-bit address MWr, 3DW header).
// On an accepted start it waits for posted header/data credits, requests the
// VC0 transmit interface, then streams six header words followed by 2*len
// payload words read from a local 16-bit RAM with one cycle of read latency.
//
// Ports
//   pcie_clk, sys_rst_n           : clock, synchronous active-low reset
//   start, dma_addr/len/src       : command strobe and descriptor
//   busy, done, err               : command status
//   bus_num, dev_num, func_num    : requester ID
//   tx_ca_ph, tx_ca_pd, tx_ca_p_recheck : posted credit inputs
//   tx_req, tx_rdy, tx_st, tx_end, tx_data : core VC0 transmit handshake
//   ram_ce, ram_adr, ram_dat      : RAM read port
module pcie_mwr_tx #(
    parameter int unsigned MAX_LEN = 32
) (
    input  logic        pcie_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [29:0] dma_addr,
    input  logic [5:0]  dma_len,
    input  logic [18:0] dma_src,
    output logic        busy,
    output logic        done,
    output logic        err,
    input  logic [7:0]  bus_num,
    input  logic [4:0]  dev_num,
    input  logic [2:0]  func_num,
    input  logic [8:0]  tx_ca_ph,
    input  logic [12:0] tx_ca_pd,
    input  logic        tx_ca_p_recheck,
    output logic        tx_req,
    input  logic        tx_rdy,
    output logic        tx_st,
    output logic        tx_end,
    output logic [15:0] tx_data,
    output logic        ram_ce,
    output logic [18:0] ram_adr,
    input  logic [15:0] ram_dat
);

    localparam int unsigned LEN_W = 6;
    localparam int unsigned CNT_W = 7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CRED,
        S_REQ,
        S_HDR,
        S_DATA
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [29:0]        addr_q;
    logic [LEN_W-1:0]   len_q;
    logic [7:0]         tag_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               done_q;
    logic               err_q;

    logic               len_valid;
    logic [LEN_W-1:0]   need_pd;
    logic               ph_ok;
    logic               pd_ok;
    logic               last_hdr;
    logic               last_dat;
    logic [CNT_W-1:0]   last_idx;
    logic               tlp_fin;

    // Command and credit qualification
    assign len_valid = (dma_len != '0) && (dma_len <= LEN_W'(MAX_LEN));
    assign need_pd   = (len_q + LEN_W'(3)) >> 2;
    assign ph_ok     = tx_ca_ph[8]  || (tx_ca_ph[7:0] != 8'd0);
    assign pd_ok     = tx_ca_pd[12] || (tx_ca_pd[11:0] >= 12'(need_pd));

    // Word counter shared by the header and payload phases
    assign last_idx  = CNT_W'({len_q, 1'b0}) - CNT_W'(1);
    assign last_hdr  = (cnt_q == CNT_W'(5));
    assign last_dat  = (cnt_q == last_idx);
    assign tlp_fin   = (state_q == S_DATA) && tx_rdy && last_dat;

    // State register
    always_ff @(posedge pcie_clk) begin
        if (!sys_rst_n) state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (start && len_valid)                      state_d = S_CRED;
            S_CRED: if (ph_ok && pd_ok && !tx_ca_p_recheck)      state_d = S_REQ;
            S_REQ:  if (tx_rdy)                                  state_d = S_HDR;
            S_HDR:  if (tx_rdy && last_hdr)                      state_d = S_DATA;
            S_DATA: if (tx_rdy && last_dat)                      state_d = S_IDLE;
            default:                                             state_d = S_IDLE;
        endcase
    end

    // Output decode; payload words pass straight from the RAM Q, which holds
    // while ram_ce is low, so a stalled word stays on tx_data.
    always_comb begin
        busy    = (state_q != S_IDLE);
        done    = done_q;
        err     = err_q;
        tx_req  = 1'b0;
        tx_st   = 1'b0;
        tx_end  = 1'b0;
        tx_data = 16'h0000;
        ram_ce  = 1'b0;
        case (state_q)
            S_REQ: tx_req = 1'b1;
            S_HDR: begin
                tx_st = (cnt_q == CNT_W'(0));
                case (cnt_q)
                    CNT_W'(0): tx_data = 16'h4000;
                    CNT_W'(1): tx_data = 16'(len_q);
                    CNT_W'(2): tx_data = {bus_num, dev_num, func_num};
                    CNT_W'(3): tx_data = {tag_q, (len_q == LEN_W'(1)) ? 4'h0 : 4'hF, 4'hF};
                    CNT_W'(4): tx_data = addr_q[29:14];
                    CNT_W'(5): tx_data = {addr_q[13:0], 2'b00};
                    default:   tx_data = 16'h0000;
                endcase
                // Prefetch payload word 0 during the last header word
                ram_ce = last_hdr && tx_rdy;
            end
            S_DATA: begin
                tx_data = ram_dat;
                tx_end  = last_dat;
                ram_ce  = tx_rdy && !last_dat;
            end
            default: ;
        endcase
    end

    // Descriptor, counters, tag and status pulses
    always_ff @(posedge pcie_clk) begin
        if (!sys_rst_n) begin
            addr_q  <= '0;
            len_q   <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ram_adr <= '0;
        end else begin
            done_q <= tlp_fin;
            err_q  <= (state_q == S_IDLE) && start && !len_valid;
            if ((state_q == S_IDLE) && start && len_valid) begin
                addr_q  <= dma_addr;
                len_q   <= dma_len;
                ram_adr <= dma_src;
            end else if (ram_ce) begin
                ram_adr <= ram_adr + 19'd1;
            end
            if (state_q != state_d)
                cnt_q <= '0;
            else if (((state_q == S_HDR) || (state_q == S_DATA)) && tx_rdy)
                cnt_q <= cnt_q + CNT_W'(1);
            if (tlp_fin)
                tag_q <= tag_q + 8'd1;
        end
    end

endmodule

// File: tb/tb_pcie_mwr_tx.sv
// Testbench for pcie_mwr_tx: directed scenarios plus randomized TLPs, each
// checked word-by-word against an expected stream built from the MWr rules.
module tb_pcie_mwr_tx;

    logic        pcie_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [29:0] dma_addr = '0;
    logic [5:0]  dma_len = '0;
    logic [18:0] dma_src = '0;
    logic        busy, done, err;
    logic [7:0]  bus_num = '0;
    logic [4:0]  dev_num = '0;
    logic [2:0]  func_num = '0;
    logic [8:0]  tx_ca_ph = 9'h100;
    logic [12:0] tx_ca_pd = 13'h1000;
    logic        tx_ca_p_recheck = 1'b0;
    logic        tx_req, tx_st, tx_end;
    logic        tx_rdy = 1'b1;
    logic [15:0] tx_data;
    logic        ram_ce;
    logic [18:0] ram_adr;
    logic [15:0] ram_dat = '0;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_tag = '0;
    logic [18:0] cur_src = '0;
    logic [15:0] exp_q[$];

    always #4 pcie_clk = ~pcie_clk;

    pcie_mwr_tx #(.MAX_LEN(32)) dut (
        .pcie_clk(pcie_clk), .sys_rst_n(sys_rst_n), .start(start),
        .dma_addr(dma_addr), .dma_len(dma_len), .dma_src(dma_src),
        .busy(busy), .done(done), .err(err),
        .bus_num(bus_num), .dev_num(dev_num), .func_num(func_num),
        .tx_ca_ph(tx_ca_ph), .tx_ca_pd(tx_ca_pd), .tx_ca_p_recheck(tx_ca_p_recheck),
        .tx_req(tx_req), .tx_rdy(tx_rdy), .tx_st(tx_st), .tx_end(tx_end),
        .tx_data(tx_data), .ram_ce(ram_ce), .ram_adr(ram_adr), .ram_dat(ram_dat)
    );

    // RAM contents as a fixed function of address
    function automatic logic [15:0] ram_word(input logic [18:0] a);
        logic [15:0] t;
        if (a == 19'd0) return 16'hAAAA;
        if (a == 19'd1) return 16'h5555;
        t = a[15:0] * 16'h9E37;
        return t ^ {13'd0, a[18:16]} ^ 16'h3C5A;
    endfunction

    // One-cycle-latency RAM with Q held while ce is low
    always @(posedge pcie_clk) if (ram_ce) ram_dat <= ram_word(ram_adr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_req"},  32'(tx_req),  32'd0);
        chk({tag, "_tx_st"},   32'(tx_st),   32'd0);
        chk({tag, "_tx_end"},  32'(tx_end),  32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_err"},     32'(err),     32'd0);
        chk({tag, "_ram_ce"},  32'(ram_ce),  32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data), 32'd0);
        chk({tag, "_ram_adr"}, 32'(ram_adr), 32'd0);
    endtask

    // Expected MWr word stream: 3DW header then 2*len payload words
    task automatic build_exp(input int len, input logic [29:0] addr, input logic [18:0] src);
        exp_q.delete();
        exp_q.push_back(16'h4000);
        exp_q.push_back(16'(len));
        exp_q.push_back({bus_num, dev_num, func_num});
        exp_q.push_back({exp_tag, (len == 1) ? 4'h0 : 4'hF, 4'hF});
        exp_q.push_back(addr[29:14]);
        exp_q.push_back({addr[13:0], 2'b00});
        for (int j = 0; j < 2 * len; j++) exp_q.push_back(ram_word(19'(src + 19'(j))));
        cur_src = src;
    endtask

    // Issue a command at a negedge; returns at the negedge of cycle 1
    task automatic start_cmd(input int len, input logic [29:0] addr, input logic [18:0] src);
        dma_len  = 6'(len);
        dma_addr = addr;
        dma_src  = src;
        start    = 1'b1;
        @(negedge pcie_clk);
        start    = 1'b0;
    endtask

    task automatic expect_req_after(input int n);
        for (int i = 0; i < n; i++) begin
            chk("req_wait_low", 32'(tx_req), 32'd0);
            chk("req_wait_busy", 32'(busy), 32'd1);
            @(negedge pcie_clk);
        end
        chk("req_high", 32'(tx_req), 32'd1);
    endtask

    // Called at the negedge where tx_req=1 and tx_rdy=1 (grant cycle k)
    task automatic stream(input int stall_idx, input int stall_n);
        int n;
        logic [18:0] adr_hold;
        n = exp_q.size();
        for (int i = 0; i < n; i++) begin
            @(negedge pcie_clk);
            chk($sformatf("word%0d", i), 32'(tx_data), 32'(exp_q[i]));
            chk($sformatf("st%0d", i),   32'(tx_st),   32'(i == 0));
            chk($sformatf("end%0d", i),  32'(tx_end),  32'(i == n - 1));
            if (i == 0) chk("req_drop", 32'(tx_req), 32'd0);
            if (i == 5) begin
                chk("prefetch_ce",  32'(ram_ce),  32'd1);
                chk("prefetch_adr", 32'(ram_adr), 32'(cur_src));
            end
            if (i == stall_idx && stall_n > 0) begin
                adr_hold = ram_adr;
                tx_rdy = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge pcie_clk);
                    chk($sformatf("stall_data%0d", i), 32'(tx_data), 32'(exp_q[i]));
                    chk($sformatf("stall_end%0d", i),  32'(tx_end),  32'(i == n - 1));
                    chk("stall_ce",  32'(ram_ce),  32'd0);
                    chk("stall_adr", 32'(ram_adr), 32'(adr_hold));
                end
                tx_rdy = 1'b1;
            end
        end
        @(negedge pcie_clk);
        chk("done_pulse", 32'(done),   32'd1);
        chk("done_busy",  32'(busy),   32'd0);
        chk("done_end",   32'(tx_end), 32'd0);
        exp_tag = exp_tag + 8'd1;
    endtask

    initial begin
        int len;
        int need;
        logic [29:0] addr;
        logic [18:0] src;
        int n;

        // Reset state
        repeat (3) @(negedge pcie_clk);
        chk_reset_outputs("reset");
        sys_rst_n = 1'b1;
        @(negedge pcie_clk);

        // Single-DW write, infinite credits, tx_rdy tied high
        bus_num = 8'd2; dev_num = 5'd0; func_num = 3'd0;
        build_exp(1, 30'h0400_0010, 19'd0);
        start_cmd(1, 30'h0400_0010, 19'd0);
        chk("t1_busy", 32'(busy), 32'd1);
        expect_req_after(1);
        stream(-1, 0);

        // 32-DW write blocked on data credits; an ignored start while busy
        tx_ca_ph = 9'd1; tx_ca_pd = 13'd7;
        build_exp(32, 30'h0123_4567, 19'd100);
        start_cmd(32, 30'h0123_4567, 19'd100);
        for (int i = 0; i < 5; i++) begin
            chk("cred_req_low", 32'(tx_req), 32'd0);
            chk("cred_busy",    32'(busy),   32'd1);
            if (i == 2) begin
                dma_len = 6'd0; dma_addr = 30'h3FFF_FFFF; dma_src = 19'd7;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge pcie_clk);
            if (i == 3) chk("busy_start_no_err", 32'(err), 32'd0);
        end
        tx_ca_pd = 13'd8;
        @(negedge pcie_clk);
        chk("cred_req_high", 32'(tx_req), 32'd1);
        stream(-1, 0);
        tx_ca_ph = 9'h100; tx_ca_pd = 13'h1000;

        // Recheck holds the request off; stall at data word 5
        bus_num = 8'h5A; dev_num = 5'd3; func_num = 3'd6;
        build_exp(4, 30'h2AAA_5555, 19'd40);
        tx_ca_p_recheck = 1'b1;
        start_cmd(4, 30'h2AAA_5555, 19'd40);
        for (int r = 0; r < 3; r++) begin
            chk("recheck_req_low", 32'(tx_req), 32'd0);
            if (r == 2) tx_ca_p_recheck = 1'b0;
            @(negedge pcie_clk);
        end
        chk("recheck_req_high", 32'(tx_req), 32'd1);
        stream(6 + 5, 4);

        // Illegal lengths
        for (int k = 0; k < 2; k++) begin
            start_cmd((k == 0) ? 0 : 33, 30'h0000_1000, 19'd0);
            chk($sformatf("err_pulse%0d", k), 32'(err),  32'd1);
            chk($sformatf("err_busy%0d", k),  32'(busy), 32'd0);
            @(negedge pcie_clk);
            chk($sformatf("err_clear%0d", k), 32'(err),    32'd0);
            chk($sformatf("err_noreq%0d", k), 32'(tx_req), 32'd0);
            chk($sformatf("err_busy2_%0d", k), 32'(busy),  32'd0);
        end

        // Reset during header word 3, then tag restarts at 0
        build_exp(2, 30'h0000_0100, 19'd9);
        start_cmd(2, 30'h0000_0100, 19'd9);
        expect_req_after(1);
        for (int i = 0; i < 4; i++) begin
            @(negedge pcie_clk);
            chk($sformatf("pre_rst_word%0d", i), 32'(tx_data), 32'(exp_q[i]));
        end
        sys_rst_n = 1'b0;
        @(negedge pcie_clk);
        chk_reset_outputs("midrst");
        sys_rst_n = 1'b1;
        exp_tag = 8'd0;
        @(negedge pcie_clk);
        chk("midrst_no_done", 32'(done), 32'd0);
        build_exp(2, 30'h0000_0100, 19'd9);
        start_cmd(2, 30'h0000_0100, 19'd9);
        expect_req_after(1);
        stream(-1, 0);

        // Randomized TLPs with finite but sufficient credits and one stall each
        for (int t = 0; t < 8; t++) begin
            len  = int'($urandom_range(1, 32));
            need = (len + 3) / 4;
            addr = 30'($urandom);
            src  = (t == 0) ? 19'h7FFF8 : 19'($urandom);
            bus_num = 8'($urandom); dev_num = 5'($urandom); func_num = 3'($urandom);
            tx_ca_ph = (t % 3 == 0) ? 9'h100 : 9'($urandom_range(1, 255));
            tx_ca_pd = 13'(need + int'($urandom_range(0, 3)));
            n = 6 + 2 * len;
            build_exp(len, addr, src);
            start_cmd(len, addr, src);
            expect_req_after(1);
            stream(int'($urandom_range(0, n - 1)), int'($urandom_range(1, 4)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
